// File: rtl/fdiv_pkg.sv
// Shared FP32 field layout, special-value constants, status flag positions
// and sequencer state encoding for the FP32 divide issue/collect block.
package fdiv_pkg;

    localparam int FP_W     = 32;
    localparam int EXP_W    = 8;
    localparam int MANT_W   = 23;
    localparam int EXP_LSB  = MANT_W;
    localparam int EXP_MSB  = MANT_W + EXP_W - 1;
    localparam int SIGN_BIT = FP_W - 1;

    localparam logic [FP_W-1:0]  QNAN    = 32'h7FC00000;
    localparam logic [EXP_W-1:0] EXP_MAX = 8'hFF;

    localparam int FLAG_W = 3;
    localparam int FL_DZ  = 0;
    localparam int FL_INV = 1;
    localparam int FL_TO  = 2;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CLR  = 2'd1,
        RUN  = 2'd2,
        HOLD = 2'd3
    } state_t;

    function automatic logic [FLAG_W-1:0] flag_bit(input int idx);
        flag_bit      = '0;
        flag_bit[idx] = 1'b1;
    endfunction

    // Denormals flush: any zero exponent counts as zero.
    function automatic logic fp_is_zero(input logic [FP_W-1:0] x);
        fp_is_zero = (x[EXP_MSB:EXP_LSB] == '0);
    endfunction

    function automatic logic fp_is_inf(input logic [FP_W-1:0] x);
        fp_is_inf = (x[EXP_MSB:EXP_LSB] == EXP_MAX) && (x[MANT_W-1:0] == '0);
    endfunction

    function automatic logic fp_is_nan(input logic [FP_W-1:0] x);
        fp_is_nan = (x[EXP_MSB:EXP_LSB] == EXP_MAX) && (x[MANT_W-1:0] != '0);
    endfunction

endpackage

// File: rtl/fdiv_seq_ctrl_f32_if.sv
// Operand and result handshake bundle between a producer/consumer and the
// divide sequencer; master is the client side, slave is the sequencer.
interface fdiv_seq_ctrl_f32_if;
    import fdiv_pkg::*;

    logic              in_valid;
    logic              in_ready;
    logic [FP_W-1:0]   in_num;
    logic [FP_W-1:0]   in_den;
    logic              out_valid;
    logic              out_ready;
    logic [FP_W-1:0]   out_quo;
    logic [FLAG_W-1:0] out_flags;

    modport master (
        output in_valid, in_num, in_den, out_ready,
        input  in_ready, out_valid, out_quo, out_flags
    );

    modport slave (
        input  in_valid, in_num, in_den, out_ready,
        output in_ready, out_valid, out_quo, out_flags
    );

endinterface

// File: rtl/fdiv_special_f32.sv
// Combinational IEEE special-case resolver: decides whether a num/den pair
// can be answered without the divide core, and what that answer is.
module fdiv_special_f32
    import fdiv_pkg::*;
(
    input  logic [FP_W-1:0]   num,
    input  logic [FP_W-1:0]   den,
    output logic              is_special,
    output logic [FP_W-1:0]   special_quo,
    output logic [FLAG_W-1:0] special_flags
);

    logic num_zero, num_inf, num_nan;
    logic den_zero, den_inf, den_nan;
    logic sign;

    always_comb begin
        num_zero = fp_is_zero(num);
        num_inf  = fp_is_inf(num);
        num_nan  = fp_is_nan(num);
        den_zero = fp_is_zero(den);
        den_inf  = fp_is_inf(den);
        den_nan  = fp_is_nan(den);
        sign     = num[SIGN_BIT] ^ den[SIGN_BIT];

        is_special    = 1'b1;
        special_quo   = '0;
        special_flags = '0;

        // Priority order matters: NaN and indeterminate forms beat divide-by-zero.
        if (num_nan || den_nan || (num_zero && den_zero) || (num_inf && den_inf)) begin
            special_quo   = QNAN;
            special_flags = flag_bit(FL_INV);
        end else if (den_zero) begin
            special_quo   = {sign, EXP_MAX, {MANT_W{1'b0}}};
            special_flags = flag_bit(FL_DZ);
        end else if (num_inf) begin
            special_quo   = {sign, EXP_MAX, {MANT_W{1'b0}}};
        end else if (num_zero || den_inf) begin
            special_quo   = {sign, {(FP_W-1){1'b0}}};
        end else begin
            is_special    = 1'b0;
        end
    end

endmodule

// File: rtl/fdiv_seq_ctrl_f32.sv
// Issue/collect sequencer around the FP32 divide core: answers special cases
// directly, otherwise resets the core, waits for rdy under a watchdog, returns.
module fdiv_seq_ctrl_f32
    import fdiv_pkg::*;
#(
    parameter int MAX_ITER = 16,
    parameter int CNT_W    = 5
) (
    input  logic                      clk,
    input  logic                      rst,
    fdiv_seq_ctrl_f32_if.slave        bus,
    output logic                      core_rst,
    output logic [FP_W-1:0]           core_num,
    output logic [FP_W-1:0]           core_den,
    input  logic                      core_rdy,
    input  logic [FP_W-1:0]           core_quo
);

    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(MAX_ITER - 1);

    state_t            state;
    logic              clr_q;
    logic [CNT_W-1:0]  cnt;
    logic              accept;
    logic              is_special;
    logic [FP_W-1:0]   special_quo;
    logic [FLAG_W-1:0] special_flags;

    fdiv_special_f32 u_special (
        .num           (bus.in_num),
        .den           (bus.in_den),
        .is_special    (is_special),
        .special_quo   (special_quo),
        .special_flags (special_flags)
    );

    assign bus.in_ready = (state == IDLE) & ~rst;
    assign accept       = bus.in_valid & bus.in_ready;
    // clr_q is registered, so the core reset never glitches on state decode.
    assign core_rst     = rst | clr_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state         <= IDLE;
            clr_q         <= 1'b0;
            cnt           <= '0;
            core_num      <= '0;
            core_den      <= '0;
            bus.out_valid <= 1'b0;
            bus.out_quo   <= '0;
            bus.out_flags <= '0;
        end else begin
            unique case (state)
                IDLE: begin
                    if (accept) begin
                        core_num <= bus.in_num;
                        core_den <= bus.in_den;
                        if (is_special) begin
                            bus.out_quo   <= special_quo;
                            bus.out_flags <= special_flags;
                            bus.out_valid <= 1'b1;
                            state         <= HOLD;
                        end else begin
                            clr_q <= 1'b1;
                            state <= CLR;
                        end
                    end
                end
                CLR: begin
                    clr_q <= 1'b0;
                    cnt   <= '0;
                    state <= RUN;
                end
                RUN: begin
                    cnt <= cnt + 1'b1;
                    // A ready core wins over a watchdog expiry in the same cycle.
                    if (core_rdy) begin
                        bus.out_quo   <= core_quo;
                        bus.out_flags <= '0;
                        bus.out_valid <= 1'b1;
                        state         <= HOLD;
                    end else if (cnt == CNT_LAST) begin
                        bus.out_quo   <= core_quo;
                        bus.out_flags <= flag_bit(FL_TO);
                        bus.out_valid <= 1'b1;
                        state         <= HOLD;
                    end
                end
                HOLD: begin
                    if (bus.out_ready) begin
                        bus.out_valid <= 1'b0;
                        state         <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: doc/fdiv_seq_ctrl_f32.md
Name: fdiv_seq_ctrl_f32

Overview:
- Issue/collect sequencer that sits upstream and downstream of the Newton-Raphson FP32 divide core (`divide_f32`).
- Accepts num/den operands over a valid/ready handshake and resolves IEEE special cases without invoking the core.
- For normal operands: pulses the core reset, holds the operands stable, waits for core `rdy` (bounded by an iteration watchdog), then presents the quotient and status flags over a valid/ready output handshake.

Parameters:
- MAX_ITER, 16, max RUN cycles to wait for core_rdy before timeout
- CNT_W, 5, iteration counter width; must hold MAX_ITER

Ports:
- clk  in  1  clock, rising edge
- rst  in  1  asynchronous, active-high reset
- in_valid  in  1  operand pair valid
- in_ready  out  1  block can accept operands
- in_num  in  32  FP32 numerator
- in_den  in  32  FP32 denominator
- out_valid  out  1  result valid
- out_ready  in  1  consumer accepts result
- out_quo  out  32  FP32 quotient
- out_flags  out  3  [0] div_by_zero, [1] invalid, [2] timeout
- core_rst  out  1  reset to divide core
- core_num  out  32  numerator to core
- core_den  out  32  denominator to core
- core_rdy  in  1  core result ready
- core_quo  in  32  core quotient

Behaviour:
- Reset (async, rst=1):
  - state=IDLE; in_ready=0 while rst high.
  - out_valid=0, out_quo=0, out_flags=0, core_num=0, core_den=0, counter=0.
  - core_rst=1 (core_rst = rst | clr_q; clr_q is a register, so the output is glitch-free).
- in_ready = (state==IDLE) & !rst.
- Accept occurs on the edge where in_valid & in_ready. Both operands are latched into core_num/core_den and held until the next accept.
- Special-case classification at accept, first match wins. exp = bits[30:23]; exp==0 is treated as zero (denormals flush); s = num[31]^den[31].
  1. Either operand NaN (exp FF, mant≠0) -> 7FC00000, invalid.
  2. num zero & den zero -> 7FC00000, invalid.
  3. num inf & den inf -> 7FC00000, invalid.
  4. den zero -> {s,8'hFF,23'd0}, div_by_zero.
  5. num inf -> {s,8'hFF,23'd0}, no flag.
  6. num zero or den inf -> {s,31'd0}, no flag.
  7. Otherwise: normal path.
- States:
  - IDLE: on accept, special -> HOLD (result/flags registered on the same edge). Normal -> CLR.
  - CLR: clr_q=1 for exactly one cycle; counter cleared. Next state RUN.
  - RUN: clr_q=0; counter increments each cycle.
    - core_rdy=1 sampled: out_quo<=core_quo, flags<=0, -> HOLD.
    - Else if counter==MAX_ITER-1: out_quo<=core_quo, flags<=3'b100, -> HOLD.
    - core_rdy wins over timeout on the same cycle.
  - HOLD: out_valid=1; out_quo/out_flags stable. On out_valid & out_ready -> IDLE, out_valid<=0.
- Latency, accept at edge T:
  - Special case: out_valid at T+1.
  - Normal: CLR in cycle T+1, RUN from T+2. out_valid one cycle after the first RUN cycle with core_rdy=1.
  - Timeout: out_valid at T+2+MAX_ITER.
- No new operand is accepted in the same cycle a result is consumed; in_ready rises the cycle after the HOLD handshake. Throughput is one op in flight.
- out_valid must not drop, and out_quo must not change, while out_ready=0.
- A stale core_rdy left high from a prior op is ignored outside RUN; CLR guarantees the core has been reset before RUN.
- rst mid-RUN or mid-HOLD: the operation is abandoned and no output is produced. core_rst is asserted for the duration of rst.

Decomposition:
- Package fdiv_pkg:
  - FP32 field widths/positions.
  - QNAN=32'h7FC00000, EXP_MAX=8'hFF.
  - Flag bit indices FL_DZ=0, FL_INV=1, FL_TO=2.
  - State encodings IDLE/CLR/RUN/HOLD.
- Sub-module fdiv_special_f32 (combinational): inputs num/den; outputs is_special, special_quo[31:0], special_flags[2:0].

Test Plan:
- 6.0/2.0 (40C00000/40000000), out_ready=1, real core -> out_quo within 1 ulp of 40400000, flags=000, in_ready high again after the handshake.
- 1.0/0.0 (3F800000/00000000) -> out_valid at T+1, out_quo=7F800000, flags=001, core_rst never pulsed. -1.0/0.0 -> FF800000.
- 0/0, NaN/2.0 (7FC00001/40000000), inf/inf -> each gives out_quo=7FC00000, flags=010.
- Stub core holding core_rdy=0, MAX_ITER=4 -> out_valid exactly at T+6, flags=100, out_quo=stub core_quo.
- Backpressure: out_ready=0 for 10 cycles after out_valid -> out_quo/flags stable, in_ready=0, no new accept. Releasing out_ready -> one handshake, then IDLE.
- rst asserted during RUN -> next edge shows out_valid=0, core_rst=1, in_ready=0. After release, in_ready=1 and a fresh 3.0/1.5 op completes with quotient 40000000.
